// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for a DDS generator.
// Steps module_step from f_begin towards f_end by f_inc. Each step is held for
// a latched dwell time, and a done pulse is issued when the sweep completes.
// The DDS output settles two cycles after module_step changes, and
// data_valid marks the cycles that follow that settling time.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last step/index
// DWELL | sweep running, holding module_step for the dwell time
// DONE  | one-cycle completion pulse; may accept a new start
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         f_begin,
  input  logic [7:0]         f_end,
  input  logic [7:0]         f_inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic [7:0]         module_step,
  output logic               step_strobe,
  output logic               data_valid,
  output logic [7:0]         sweep_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t             state, state_nx;
  logic [7:0]         f_end_lat, f_inc_lat;
  logic [7:0]         end_nx, inc_nx;
  logic [DWELL_W-1:0] dwell_lat, dw_nx;
  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [1:0]         age, age_nx;
  logic [7:0]         step_nx, idx_nx;
  logic               strobe_nx, dv_nx, busy_nx, done_nx;
  logic [8:0]         next9;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      f_end_lat   <= '0;
      f_inc_lat   <= '0;
      dwell_lat   <= '0;
      cnt         <= '0;
      age         <= '0;
      module_step <= '0;
      sweep_idx   <= '0;
      step_strobe <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      f_end_lat   <= end_nx;
      f_inc_lat   <= inc_nx;
      dwell_lat   <= dw_nx;
      cnt         <= cnt_nx;
      age         <= age_nx;
      module_step <= step_nx;
      sweep_idx   <= idx_nx;
      step_strobe <= strobe_nx;
      data_valid  <= dv_nx;
      busy        <= busy_nx;
      done        <= done_nx;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nx  = state;
    end_nx    = f_end_lat;
    inc_nx    = f_inc_lat;
    dw_nx     = dwell_lat;
    cnt_nx    = cnt;
    age_nx    = age;
    step_nx   = module_step;
    idx_nx    = sweep_idx;
    strobe_nx = 1'b0;
    dv_nx     = 1'b0;
    next9     = {1'b0, module_step} + {1'b0, f_inc_lat};

    case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        if (start && !abort) begin
          state_nx  = DWELL;
          step_nx   = f_begin;
          idx_nx    = 8'd0;
          end_nx    = f_end;
          inc_nx    = f_inc;
          dw_nx     = (dwell == '0) ? DWELL_W'(1) : dwell;
          cnt_nx    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          age_nx    = 2'd0;
          strobe_nx = 1'b1;
        end
      end
      DWELL: begin
        if (abort) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          age_nx   = 2'd0;
        end else if (cnt == '0) begin
          age_nx = 2'd0;
          if (f_inc_lat == 8'd0 || next9[8] || next9[7:0] > f_end_lat) begin
            state_nx = DONE;
          end else begin
            step_nx   = next9[7:0];
            idx_nx    = sweep_idx + 8'd1;
            cnt_nx    = dwell_lat - DWELL_W'(1);
            strobe_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt - DWELL_W'(1);
          age_nx = (age == 2'd2) ? 2'd2 : age + 2'd1;
          dv_nx  = (age != 2'd0);
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx == DWELL);
    done_nx = (state_nx == DONE);
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: expected per-cycle outputs are queued
// when a sweep is started and popped/compared one cycle at a time.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [7:0]  f_begin, f_end, f_inc;
  logic [15:0] dwell;
  logic [7:0]  module_step, sweep_idx;
  logic        step_strobe, data_valid, busy, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] step;
    logic       strobe;
    logic       dv;
    logic [7:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   last_v, last_idx;

  dds_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .f_begin(f_begin), .f_end(f_end), .f_inc(f_inc), .dwell(dwell),
    .module_step(module_step), .step_strobe(step_strobe),
    .data_valid(data_valid), .sweep_idx(sweep_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int v, input bit s, input bit dv, input int idx,
                      input bit b, input bit d);
    exp_t e;
    e.step = 8'(v); e.strobe = s; e.dv = dv; e.idx = 8'(idx); e.busy = b; e.done = d;
    sb.push_back(e);
  endtask

  // Expected outputs of a full sweep: every busy cycle plus the DONE cycle.
  task automatic push_sweep(input int fb, input int fe, input int fi, input int d,
                            output int lv, output int li);
    int deff, v, idx, nxt;
    deff = (d == 0) ? 1 : d;
    v = fb; idx = 0;
    forever begin
      for (int p = 0; p < deff; p++) push(v, p == 0, p >= 2, idx, 1'b1, 1'b0);
      nxt = v + fi;
      if (fi == 0 || nxt > 255 || nxt > fe) break;
      v = nxt; idx = (idx + 1) % 256;
    end
    push(v, 1'b0, 1'b0, idx, 1'b0, 1'b1);
    lv = v; li = idx;
  endtask

  task automatic push_idle(input int v, input int idx, input int n);
    for (int i = 0; i < n; i++) push(v, 1'b0, 1'b0, idx, 1'b0, 1'b0);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
        continue;
      end
      e = sb.pop_front();
      chk("module_step", 32'(module_step), 32'(e.step));
      chk("step_strobe", 32'(step_strobe), 32'(e.strobe));
      chk("data_valid",  32'(data_valid),  32'(e.dv));
      chk("sweep_idx",   32'(sweep_idx),   32'(e.idx));
      chk("busy",        32'(busy),        32'(e.busy));
      chk("done",        32'(done),        32'(e.done));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_step"},   32'(module_step), 0);
    chk({tag, "_idx"},    32'(sweep_idx),   0);
    chk({tag, "_strobe"}, 32'(step_strobe), 0);
    chk({tag, "_dv"},     32'(data_valid),  0);
    chk({tag, "_busy"},   32'(busy),        0);
    chk({tag, "_done"},   32'(done),        0);
  endtask

  task automatic set_cfg(input int fb, input int fe, input int fi, input int d);
    f_begin = 8'(fb); f_end = 8'(fe); f_inc = 8'(fi); dwell = 16'(d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    set_cfg(0, 0, 0, 0);
    #3;
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;
    push_idle(0, 0, 2);
    run(2);

    // Basic sweep 10..20 step 5, dwell 4
    set_cfg(10, 20, 5, 4); start = 1'b1;
    push_sweep(10, 20, 5, 4, last_v, last_idx);
    push_idle(last_v, last_idx, 2);
    run(1); start = 1'b0;
    run(sb.size());

    // Overflow past 255 terminates the sweep
    set_cfg(250, 255, 4, 1); start = 1'b1;
    push_sweep(250, 255, 4, 1, last_v, last_idx);
    push_idle(last_v, last_idx, 1);
    run(1); start = 1'b0;
    run(sb.size());

    // f_begin > f_end with dwell 0
    set_cfg(30, 20, 1, 0); start = 1'b1;
    push_sweep(30, 20, 1, 0, last_v, last_idx);
    push_idle(last_v, last_idx, 1);
    run(1); start = 1'b0;
    run(sb.size());

    // f_inc = 0 gives a single step
    set_cfg(5, 100, 0, 2); start = 1'b1;
    push_sweep(5, 100, 0, 2, last_v, last_idx);
    push_idle(last_v, last_idx, 1);
    run(1); start = 1'b0;
    run(sb.size());

    // Abort together with start at step 7; start held high throughout
    set_cfg(0, 255, 1, 3); start = 1'b1;
    for (int s = 0; s < 7; s++)
      for (int p = 0; p < 3; p++) push(s, p == 0, p >= 2, s, 1'b1, 1'b0);
    push(7, 1'b1, 1'b0, 7, 1'b1, 1'b0);
    run(1);
    set_cfg(99, 150, 9, 9);
    run(sb.size());
    abort = 1'b1;
    push_idle(7, 7, 2);
    run(2);
    abort = 1'b0; start = 1'b0;
    push_idle(7, 7, 2);
    run(2);

    // Asynchronous reset mid-sweep, then a fresh sweep
    set_cfg(10, 200, 10, 5); start = 1'b1;
    push_sweep(10, 200, 10, 5, last_v, last_idx);
    run(1); start = 1'b0;
    run(3);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    sb.delete();
    @(negedge clk); rst = 1'b0;
    set_cfg(40, 60, 20, 2); start = 1'b1;
    push_sweep(40, 60, 20, 2, last_v, last_idx);
    push_idle(last_v, last_idx, 1);
    run(1); start = 1'b0;
    run(sb.size());

    // Restart from DONE with new config; config changes while busy ignored
    set_cfg(1, 3, 1, 1); start = 1'b1;
    push_sweep(1, 3, 1, 1, last_v, last_idx);
    run(1); start = 1'b0;
    set_cfg(200, 201, 0, 7);
    run(3);
    set_cfg(50, 52, 2, 2); start = 1'b1;
    push_sweep(50, 52, 2, 2, last_v, last_idx);
    push_idle(last_v, last_idx, 2);
    run(1); start = 1'b0;
    set_cfg(0, 255, 1, 20);
    run(sb.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, width of the dwell counter and of the dwell input.
REQ-002 SHALL have ports, one per line:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a sweep; sampled in IDLE/DONE only
- abort  input  1  terminate the sweep in progress
- f_begin  input  8  first frequency multiple
- f_end  input  8  last allowed frequency multiple, inclusive
- f_inc  input  8  increment between steps
- dwell  input  DWELL_W  cycles spent on each step; 0 treated as 1
- module_step  output  8  frequency multiple driven to the DDS generator (2-cycle output latency)
- step_strobe  output  1  one-cycle pulse on the first cycle of each new module_step value
- data_valid  output  1  DDS output corresponds to current module_step
- sweep_idx  output  8  index of current step, 0 for f_begin
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse on normal sweep completion

Function
REQ-003 SHALL implement states IDLE, DWELL, DONE; busy=1 only in DWELL.
REQ-004 In IDLE or DONE with start=1 and abort=0, SHALL latch f_begin, f_end, f_inc and dwell (0->1) and enter DWELL at the next edge.
REQ-005 On DWELL entry, module_step SHALL = f_begin, sweep_idx=0, step_strobe=1 for that first cycle.
REQ-006 Inputs f_begin/f_end/f_inc/dwell SHALL be ignored while busy; start while busy SHALL be ignored.
REQ-007 Each step SHALL hold module_step for exactly the latched dwell cycles.
REQ-008 At step end, SHALL compute next = module_step + f_inc in 9 bits; if f_inc=0, or next[8]=1 (overflow), or next[7:0] > f_end, SHALL go to DONE; otherwise module_step<=next[7:0], sweep_idx+1 (wraps mod 256), step_strobe pulses.
REQ-009 If f_begin > f_end, the sweep SHALL consist of f_begin alone for one dwell period.
REQ-010 data_valid SHALL be 0 in the first 2 cycles of each step and 1 for its remaining cycles; SHALL be 0 outside DWELL; with dwell<=2 it is never asserted.
REQ-011 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE unless start is accepted there (REQ-004).
REQ-012 abort=1 in DWELL SHALL force IDLE at the next edge without done; abort SHALL take priority over start and over step advance.
REQ-013 After completion or abort, module_step and sweep_idx SHALL hold their last values (DDS keeps running).
REQ-014 step_strobe, done and data_valid SHALL be registered outputs, glitch-free.

Reset
REQ-015 rst=1 SHALL asynchronously force state IDLE, module_step=0, sweep_idx=0, step_strobe=0, data_valid=0, busy=0, done=0, dwell counter=0, latched config=0.
REQ-016 Reset asserted mid-sweep SHALL abandon the sweep without done; the first start after rst deassertion SHALL behave as REQ-004.

Verification
REQ-017 Bench SHALL cover:
- f_begin=10,f_end=20,f_inc=5,dwell=4, start 1 cycle -> module_step 10,15,20 each 4 cycles, step_strobe 3 pulses 4 cycles apart, sweep_idx 0,1,2, data_valid high cycles 3-4 of each step, done 1 cycle after last step, busy 12 cycles.
- f_begin=250,f_end=255,f_inc=4,dwell=1 -> module_step 250,254 then done (258 overflow), data_valid never 1.
- f_begin=30,f_end=20,f_inc=1,dwell=0 -> single step 30 for 1 cycle then done; also f_inc=0 -> single step f_begin.
- sweep 0..255 step 1 dwell 3; abort asserted with start same cycle at step 7 -> IDLE next edge, no done, module_step holds 7, start ignored.
- rst pulsed asynchronously (between edges) mid-sweep -> all outputs 0 immediately; new start afterwards sweeps from its f_begin correctly.
- start asserted in DONE cycle with new config -> new sweep begins next edge, done not repeated; config changes during busy have no effect.
